// File: rtl/ibi_retry_ctrl_pkg.sv
// Shared types for the IBI retry controller: FSM states and the completion
// status codes reported to the host side.
package ibi_retry_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_SEND,
    ST_WAIT_STATUS,
    ST_BACKOFF,
    ST_REPORT
  } ibi_state_e;

  typedef enum logic [1:0] {
    IBI_OK         = 2'd0,
    IBI_RETRY_FAIL = 2'd1,
    IBI_OVERFLOW   = 2'd2,
    IBI_ABORTED    = 2'd3
  } ibi_status_e;

  localparam logic [1:0] RETRY_MAX = 2'd3;

  // Retry counter increment that sticks at RETRY_MAX.
  function automatic logic [1:0] retry_inc(input logic [1:0] r);
    return (r == RETRY_MAX) ? r : r + 2'd1;
  endfunction

endpackage

// File: rtl/ibi_retry_ctrl_byte_buf.sv
// Replay buffer for one IBI: single write port, combinational read port.
// Contents are not reset; only cnt/rd_ptr in the controller qualify them.
module ibi_byte_buf
  import ibi_retry_ctrl_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem [Depth];

  // Capture one upstream byte per accepted beat.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ibi_retry_ctrl.sv
// IBI retry controller: buffers one IBI from the descriptor engine, sends it
// to the target FSM, and replays it from the buffer after NACK/arbitration
// loss, up to retry_limit_i times with a programmable backoff.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// ST_IDLE        | waiting for the first byte (MDB) while enabled
// ST_CAPTURE     | storing remaining bytes into the replay buffer
// ST_DRAIN       | discarding upstream bytes until last (overflow/abort)
// ST_SEND        | streaming buf[rd_ptr] to the target FSM
// ST_WAIT_STATUS | all bytes sent, waiting for ACK (done) or error
// ST_BACKOFF     | idle countdown before replaying from the MDB
// ST_REPORT      | one-cycle completion report, then back to idle
module ibi_retry_ctrl
  import ibi_retry_ctrl_pkg::*;
#(
  parameter int IbiFifoWidth = 8,
  parameter int BufDepth     = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [1:0]              retry_limit_i,
  input  logic [7:0]              backoff_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [IbiFifoWidth-1:0] in_byte_i,
  input  logic                    in_last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [IbiFifoWidth-1:0] out_byte_o,
  output logic                    out_last_o,
  input  logic                    tgt_done_i,
  input  logic                    tgt_err_i,
  output logic                    status_valid_o,
  output logic [1:0]              status_o,
  output logic [1:0]              retry_cnt_o
);

  localparam int AW = $clog2(BufDepth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(BufDepth);

  ibi_state_e        state_q, state_d;
  ibi_status_e       status_q, status_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]        retries_q, retries_d;
  logic [7:0]        timer_q, timer_d;

  logic                    buf_we;
  logic [AW-1:0]           buf_waddr;
  logic [IbiFifoWidth-1:0] buf_rdata;
  logic                    send_last;

  ibi_byte_buf #(
    .Width (IbiFifoWidth),
    .Depth (BufDepth)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (in_byte_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  assign send_last = ({1'b0, rd_ptr_q} == (cnt_q - CW'(1)));

  // Next-state, datapath updates and outputs; everything is forced quiet in reset.
  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    cnt_d          = cnt_q;
    rd_ptr_d       = rd_ptr_q;
    retries_d      = retries_q;
    timer_d        = timer_q;
    buf_we         = 1'b0;
    buf_waddr      = cnt_q[AW-1:0];
    in_ready_o     = 1'b0;
    out_valid_o    = 1'b0;
    out_byte_o     = '0;
    out_last_o     = 1'b0;
    status_valid_o = 1'b0;
    status_o       = 2'd0;
    retry_cnt_o    = 2'd0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready_o = enable_i;
        if (enable_i && in_valid_i) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          cnt_d     = CW'(1);
          rd_ptr_d  = '0;
          state_d   = in_last_i ? ST_SEND : ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
        // A disabled capture still has to swallow the rest of the stream.
        if (!enable_i) begin
          status_d = IBI_ABORTED;
          state_d  = (in_valid_i && in_last_i) ? ST_REPORT : ST_DRAIN;
        end else if (in_valid_i) begin
          if (in_last_i) begin
            state_d = ST_SEND;
          end else if ((cnt_q + CW'(1)) == DEPTH_CNT) begin
            status_d = IBI_OVERFLOW;
            state_d  = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        in_ready_o = 1'b1;
        if (in_valid_i && in_last_i) state_d = ST_REPORT;
      end

      ST_SEND: begin
        out_valid_o = 1'b1;
        out_byte_o  = buf_rdata;
        out_last_o  = send_last;
        if (!enable_i) begin
          status_d = IBI_ABORTED;
          state_d  = ST_REPORT;
        end else if (tgt_err_i) begin
          if (retries_q < retry_limit_i) begin
            retries_d = retry_inc(retries_q);
            timer_d   = backoff_i;
            state_d   = ST_BACKOFF;
          end else begin
            status_d = IBI_RETRY_FAIL;
            state_d  = ST_REPORT;
          end
        end else if (out_ready_i) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (send_last) state_d = ST_WAIT_STATUS;
        end
      end

      ST_WAIT_STATUS: begin
        if (!enable_i) begin
          status_d = IBI_ABORTED;
          state_d  = ST_REPORT;
        end else if (tgt_err_i) begin
          if (retries_q < retry_limit_i) begin
            retries_d = retry_inc(retries_q);
            timer_d   = backoff_i;
            state_d   = ST_BACKOFF;
          end else begin
            status_d = IBI_RETRY_FAIL;
            state_d  = ST_REPORT;
          end
        end else if (tgt_done_i) begin
          status_d = IBI_OK;
          state_d  = ST_REPORT;
        end
      end

      ST_BACKOFF: begin
        if (!enable_i) begin
          status_d = IBI_ABORTED;
          state_d  = ST_REPORT;
        end else if (timer_q == 8'd0) begin
          rd_ptr_d = '0;
          state_d  = ST_SEND;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      ST_REPORT: begin
        status_valid_o = 1'b1;
        status_o       = status_q;
        retry_cnt_o    = retries_q;
        cnt_d          = '0;
        rd_ptr_d       = '0;
        retries_d      = 2'd0;
        state_d        = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (rst_i) begin
      buf_we         = 1'b0;
      in_ready_o     = 1'b0;
      out_valid_o    = 1'b0;
      out_byte_o     = '0;
      out_last_o     = 1'b0;
      status_valid_o = 1'b0;
      status_o       = 2'd0;
      retry_cnt_o    = 2'd0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      status_q  <= IBI_OK;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      retries_q <= 2'd0;
      timer_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      retries_q <= retries_d;
      timer_q   <= timer_d;
    end
  end

endmodule

// File: tb/tb_ibi_retry_ctrl.sv
// Bench for ibi_retry_ctrl: directed vector table, a reset/abort sequence and
// randomized IBIs checked against a transaction-level outcome model.
module tb_ibi_retry_ctrl;

  localparam int W = 8;
  localparam int D = 64;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic [1:0]   retry_limit_i;
  logic [7:0]   backoff_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] in_byte_i;
  logic         in_last_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_byte_o;
  logic         out_last_o;
  logic         tgt_done_i;
  logic         tgt_err_i;
  logic         status_valid_o;
  logic [1:0]   status_o;
  logic [1:0]   retry_cnt_o;

  ibi_retry_ctrl #(.IbiFifoWidth(W), .BufDepth(D)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .retry_limit_i  (retry_limit_i),
    .backoff_i      (backoff_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_byte_i      (in_byte_i),
    .in_last_i      (in_last_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_byte_o     (out_byte_o),
    .out_last_o     (out_last_o),
    .tgt_done_i     (tgt_done_i),
    .tgt_err_i      (tgt_err_i),
    .status_valid_o (status_valid_o),
    .status_o       (status_o),
    .retry_cnt_o    (retry_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Status codes as the bench understands them.
  localparam int S_OK = 0, S_RFAIL = 1, S_OVF = 2, S_ABORT = 3;

  // Per-attempt target behaviour:
  // 0 = done arg cycles into wait, 1 = error while sending byte index arg,
  // 2 = error arg cycles into wait, 3 = done+error together in wait,
  // 4 = enable dropped arg cycles into wait.
  typedef struct {
    int             len;
    int             first;
    int             limit;
    int             backoff;
    int             abort_in;
    logic [3:0][7:0] mode;
    logic [3:0][7:0] arg;
    int             exp_st;
    int             exp_rt;
    int             exp_at;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int len, int first, int limit, int backoff, int abort_in,
                              int m0, int m1, int m2, int m3,
                              int a0, int a1, int a2, int a3,
                              int st, int rt, int at);
    vec_t v;
    v.len = len; v.first = first; v.limit = limit; v.backoff = backoff;
    v.abort_in = abort_in;
    v.mode = {8'(m3), 8'(m2), 8'(m1), 8'(m0)};
    v.arg  = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    v.exp_st = st; v.exp_rt = rt; v.exp_at = at;
    return v;
  endfunction

  // Outcome of one IBI derived from the retry rules alone.
  task automatic model(input vec_t v, output int st, output int rt, output int at);
    int r;
    st = S_OK; rt = 0; at = 0; r = 0;
    if (v.abort_in != 0) begin
      st = S_ABORT;
    end else if (v.len > D) begin
      st = S_OVF;
    end else begin
      for (int a = 0; a < 4; a++) begin
        at = a + 1;
        if (v.mode[a] == 0) begin st = S_OK; rt = r; break; end
        if (v.mode[a] == 4) begin st = S_ABORT; rt = r; break; end
        if (r < v.limit) r++;
        else begin st = S_RFAIL; rt = r; break; end
      end
    end
  endtask

  task automatic run_ibi(input string tag, input vec_t v, input bit rnd);
    logic [7:0] data [128];
    int  up = 0, k = 0, att = 0, wcnt = 0, gap = 0, cyc = 0;
    int  got_st = -1, got_rt = -1;
    bit  waiting = 0, started = 0, in_gap = 0, en_low = 0, done = 0, err;
    for (int i = 0; i < v.len; i++)
      data[i] = rnd ? 8'($urandom) : 8'(v.first + i * 37);
    retry_limit_i = 2'(v.limit);
    backoff_i     = 8'(v.backoff);
    while (!done && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      tgt_done_i  = 1'b0;
      tgt_err_i   = 1'b0;
      enable_i    = !en_low;
      in_valid_i  = (up < v.len) && (!rnd || $urandom_range(0, 3) != 0);
      in_byte_i   = (up < v.len) ? data[up] : 8'h00;
      in_last_i   = (up == v.len - 1);
      out_ready_i = !rnd || $urandom_range(0, 3) != 0;
      #1;
      err = 0;
      if (out_valid_o) begin
        if (!started) begin
          started = 1;
          att++;
          if (att > 1) check({tag, ".backoff_gap"}, gap, v.backoff + 1);
          in_gap = 0;
        end
        if (k >= v.len) begin
          n_cmp++; n_bad++;
          $display("FAIL %s.extra_byte: got byte index %0d, expected at most %0d", tag, k, v.len - 1);
        end else if (v.mode[att-1] == 1 && k == int'(v.arg[att-1])) begin
          tgt_err_i   = 1'b1;
          out_ready_i = 1'b0;
          err = 1;
        end
      end else if (waiting) begin
        wcnt++;
        if (wcnt == int'(v.arg[att-1])) begin
          case (v.mode[att-1])
            0: tgt_done_i = 1'b1;
            2: begin tgt_err_i = 1'b1; err = 1; end
            3: begin tgt_done_i = 1'b1; tgt_err_i = 1'b1; err = 1; end
            4: begin enable_i = 1'b0; en_low = 1; end
            default: ;
          endcase
        end
      end else if (in_gap) begin
        gap++;
      end
      #1;
      if (in_valid_i && in_ready_o) up++;
      if (out_valid_o && out_ready_i && k < v.len) begin
        check({tag, ".byte"}, out_byte_o, data[k]);
        check({tag, ".last"}, out_last_o, (k == v.len - 1) ? 1 : 0);
        check({tag, ".in_ready_in_send"}, in_ready_o, 0);
        k++;
        if (k == v.len) begin waiting = 1; wcnt = 0; end
      end
      if (err) begin started = 0; waiting = 0; k = 0; in_gap = 1; gap = 0; end
      if (status_valid_o) begin done = 1; got_st = status_o; got_rt = retry_cnt_o; end
      if (v.abort_in != 0 && up == v.abort_in) en_low = 1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: got no status after %0d cycles, expected a report", tag, cyc);
    end
    check({tag, ".status"}, got_st, v.exp_st);
    check({tag, ".retry_cnt"}, got_rt, v.exp_rt);
    check({tag, ".attempts"}, att, v.exp_at);
    check({tag, ".accepted"}, up, v.len);
    @(negedge clk_i);
    enable_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0;
    tgt_done_i = 1'b0; tgt_err_i = 1'b0; out_ready_i = 1'b0;
    #1;
    check({tag, ".status_one_cycle"}, status_valid_o, 0);
  endtask

  vec_t tbl [10];
  vec_t rv;

  initial begin
    //           len first lim bo ab  m0 m1 m2 m3  a0 a1 a2 a3  st rt at
    tbl[0] = mk(  4, 'hA5, 0, 0, 0,  0, 0, 0, 0,  2, 1, 1, 1,  S_OK,    0, 1);
    tbl[1] = mk(  4, 'h5A, 2, 5, 0,  1, 0, 0, 0,  2, 1, 1, 1,  S_OK,    1, 2);
    tbl[2] = mk(  5, 'h3C, 1, 2, 0,  1, 2, 0, 0,  3, 1, 1, 1,  S_RFAIL, 1, 2);
    tbl[3] = mk( 70, 'h11, 3, 1, 0,  0, 0, 0, 0,  2, 1, 1, 1,  S_OVF,   0, 0);
    tbl[4] = mk(  3, 'h77, 3, 2, 0,  3, 0, 0, 0,  1, 1, 1, 1,  S_OK,    1, 2);
    tbl[5] = mk(  1, 'h80, 3, 0, 0,  1, 1, 1, 1,  0, 0, 0, 0,  S_RFAIL, 3, 4);
    tbl[6] = mk( 64, 'h01, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 1,  S_OK,    0, 1);
    tbl[7] = mk( 65, 'hFE, 1, 0, 0,  0, 0, 0, 0,  1, 1, 1, 1,  S_OVF,   0, 0);
    tbl[8] = mk( 10, 'h42, 0, 0, 3,  0, 0, 0, 0,  1, 1, 1, 1,  S_ABORT, 0, 0);
    tbl[9] = mk(  3, 'h99, 2, 1, 0,  2, 4, 0, 0,  1, 2, 1, 1,  S_ABORT, 1, 2);

    rst_i = 1'b1; enable_i = 1'b1; retry_limit_i = 2'd0; backoff_i = 8'd0;
    in_valid_i = 1'b0; in_byte_i = '0; in_last_i = 1'b0; out_ready_i = 1'b0;
    tgt_done_i = 1'b0; tgt_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_outputs", {in_ready_o, out_valid_o, out_last_o, status_valid_o,
                            out_byte_o, status_o, retry_cnt_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0; enable_i = 1'b0;
    #1;
    check("idle_disabled_ready", in_ready_o, 0);

    for (int i = 0; i < 9; i++) run_ibi($sformatf("vec%0d", i), tbl[i], 0);

    // Reset mid-Send: 4 bytes captured, 2 sent, then a one-cycle reset.
    @(negedge clk_i);
    enable_i = 1'b1; retry_limit_i = 2'd0; backoff_i = 8'd0;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1; in_byte_i = 8'(8'hC0 + i); in_last_i = (i == 3);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b1;
    #1;
    check("rst_seq.in_send", out_valid_o, 1);
    check("rst_seq.mdb", out_byte_o, 8'hC0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rst_seq.during_reset", {in_ready_o, out_valid_o, out_last_o, status_valid_o,
                                   out_byte_o, status_o, retry_cnt_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0; enable_i = 1'b0; out_ready_i = 1'b0;
    #1;
    check("rst_seq.after_reset", {in_ready_o, out_valid_o, out_last_o, status_valid_o,
                                  out_byte_o, status_o, retry_cnt_o}, 0);
    run_ibi("after_rst_abort", tbl[9], 0);

    for (int r = 0; r < 40; r++) begin
      int st, rt, at, lim;
      rv.len      = $urandom_range(1, 80);
      rv.first    = 0;
      rv.limit    = $urandom_range(0, 3);
      rv.backoff  = $urandom_range(0, 6);
      rv.abort_in = 0;
      if (rv.len >= 2 && $urandom_range(0, 9) == 0) begin
        lim = (rv.len - 1 < D - 1) ? rv.len - 1 : D - 1;
        rv.abort_in = $urandom_range(1, lim);
      end
      for (int a = 0; a < 4; a++) begin
        rv.mode[a] = 8'($urandom_range(0, 4));
        rv.arg[a]  = (rv.mode[a] == 1) ? 8'($urandom_range(0, rv.len - 1))
                                       : 8'($urandom_range(1, 4));
      end
      model(rv, st, rt, at);
      rv.exp_st = st; rv.exp_rt = rt; rv.exp_at = at;
      run_ibi($sformatf("rnd%0d", r), rv, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ibi_retry_ctrl.md
IBI_RETRY_CTRL -- requirements
Module: ibi_retry_ctrl

Interface
REQ-001 SHALL have parameter IbiFifoWidth, default 8, meaning IBI byte width.
REQ-002 SHALL have parameter BufDepth, default 64, meaning replay buffer capacity in bytes (power of 2).
REQ-003 SHALL have clk_i, input, 1: the single clock.
REQ-004 SHALL have rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have enable_i, input, 1: IBI generation enabled.
REQ-006 SHALL have retry_limit_i, input, 2: maximum number of retries (0-3).
REQ-007 SHALL have backoff_i, input, 8: idle cycles between a failure and the retry.
REQ-008 SHALL have in_valid_i/in_ready_o/in_byte_i[IbiFifoWidth]/in_last_i: upstream IBI byte stream (MDB first), from the IBI descriptor engine.
REQ-009 SHALL have out_valid_o/out_ready_i/out_byte_o[IbiFifoWidth]/out_last_o: downstream byte stream to the target FSM.
REQ-010 SHALL have tgt_done_i, input, 1: target FSM reports that the IBI completed with ACK.
REQ-011 SHALL have tgt_err_i, input, 1: target FSM reports NACK or arbitration loss.
REQ-012 SHALL have status_valid_o, output, 1; status_o, output, 2; retry_cnt_o, output, 2: per-IBI completion report.

Function
REQ-013 SHALL implement the states Idle, Capture, Drain, Send, WaitStatus, Backoff and Report.
REQ-014 In Idle, in_ready_o SHALL equal enable_i; an accepted byte is written to buf[0] with cnt=1, then next state = Send if in_last_i, else Capture.
REQ-015 In Capture, in_ready_o SHALL be 1 and each accepted byte is written to buf[cnt] with cnt++.
- A last byte moves the FSM to Send.
- An accepted non-last byte that brings cnt to BufDepth moves the FSM to Drain with status OVERFLOW.
REQ-016 In Drain, in_ready_o SHALL be 1, bytes are discarded, and the FSM moves to Report on the accepted last byte.
REQ-017 In Send:
- out_valid_o=1, out_byte_o=buf[rd_ptr], out_last_o=(rd_ptr==cnt-1).
- out_ready_i increments rd_ptr; the last accepted byte moves the FSM to WaitStatus.
REQ-018 In every state except Idle, Capture and Drain, in_ready_o SHALL be 0.
REQ-019 tgt_err_i in Send or WaitStatus SHALL abort the attempt:
- If retries<retry_limit_i: retries++, timer<=backoff_i, go to Backoff.
- Otherwise: status RETRY_FAIL, go to Report.
REQ-020 In WaitStatus, tgt_done_i SHALL give status OK and a move to Report; if tgt_done_i and tgt_err_i are both high, tgt_err_i wins.
REQ-021 In Backoff, the timer SHALL decrement each cycle; at timer==0 the FSM sets rd_ptr<=0 and goes to Send (minimum 1 cycle, even when backoff_i=0).
REQ-022 In Report:
- status_valid_o=1 for exactly one cycle, with status_o and retry_cnt_o=retries.
- Next state Idle; cnt, rd_ptr and retries are cleared.
REQ-023 status_o encoding SHALL be 0 OK, 1 RETRY_FAIL, 2 OVERFLOW, 3 ABORTED.
REQ-024 enable_i low in Capture, Send, WaitStatus or Backoff SHALL force Report with ABORTED on the next cycle; upstream bytes still pending are accepted in Drain before that Report.
REQ-025 tgt_done_i/tgt_err_i outside Send/WaitStatus SHALL be ignored.
REQ-026 cnt SHALL be $clog2(BufDepth)+1 bits wide; rd_ptr SHALL be $clog2(BufDepth) bits wide; the retry counter SHALL saturate at 3.
REQ-027 A byte replayed on retry SHALL be bit-identical to the original; bytes are never re-requested upstream.

Reset
REQ-028 rst_i high SHALL put the FSM in Idle and zero cnt, rd_ptr, retries and timer on the next edge, including mid-transfer.
REQ-029 During and after reset, in_ready_o, out_valid_o, out_last_o and status_valid_o SHALL be 0; out_byte_o, status_o and retry_cnt_o SHALL be 0.
REQ-030 Buffer contents SHALL NOT require reset.

Structure
REQ-031 The state enum and the ibi_status_e encoding SHALL live in the shared i3c controller package.
REQ-032 The buffer SHALL be one sub-module, ibi_byte_buf: single write port, single combinational read port, BufDepth x IbiFifoWidth.

Verification
REQ-033 MDB 0xA5 plus 3 data bytes, out_ready_i=1, tgt_done_i 2 cycles after the last byte -> 4 bytes out, last on byte 4, status OK, retry_cnt 0.
REQ-034 retry_limit_i=2, backoff_i=5, tgt_err_i after byte 2 of the first attempt, then done -> replay from MDB after 6 idle cycles, status OK, retry_cnt 1.
REQ-035 retry_limit_i=1 with tgt_err_i on every attempt -> exactly 2 attempts, status RETRY_FAIL, retry_cnt 1.
REQ-036 A 70-byte stream with BufDepth=64 -> no out_valid_o, all 70 bytes accepted, status OVERFLOW.
REQ-037 tgt_done_i and tgt_err_i asserted together in WaitStatus with retries remaining -> Backoff entered, no OK report.
REQ-038 rst_i pulsed mid-Send, then enable_i deasserted mid-WaitStatus on a fresh IBI -> all outputs 0 after the reset edge; second IBI reports ABORTED.
